// File: rtl/dc_offset_cal.sv
// DC-offset calibration controller for the 6-bit sign-magnitude offset DAC.
// Sign decision plus 5-bit SAR search, then optional one-step tracking.
module dc_offset_cal #(
  parameter int ADC_WIDTH     = 8,
  parameter int AVG_LOG2      = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int DEADBAND      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 track_en,
  input  logic                 adc_valid,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic [ADC_WIDTH-1:0] target,
  output logic [5:0]           current_dac,
  output logic                 dac_update,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = ADC_WIDTH + AVG_LOG2;
  localparam int NS = 1 << AVG_LOG2;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int NW = AVG_LOG2 + 1;

  localparam logic [SW:0] DBS  = (SW+1)'(DEADBAND << AVG_LOG2);
  localparam logic [SW:0] MAXS = {1'b0, {SW{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCUM,
    S_DECIDE,
    S_DONE,
    S_TRACK
  } state_t;

  state_t                 r_state, w_state_d;
  logic [ADC_WIDTH-1:0]   r_tgt, w_tgt_d;
  logic [5:0]             r_dac, w_dac_d;
  logic                   r_upd, w_upd_d;
  logic                   r_busy, w_busy_d;
  logic                   r_done, w_done_d;
  logic [CW-1:0]          r_cnt, w_cnt_d;
  logic [NW-1:0]          r_nsmp, w_nsmp_d;
  logic [SW-1:0]          r_acc, w_acc_d;
  logic                   r_signph, w_signph_d;
  logic                   r_sign, w_sign_d;
  logic [2:0]             r_bit, w_bit_d;
  logic                   r_trk, w_trk_d;

  logic [SW-1:0]          w_tgt_sum;
  logic [SW:0]            w_tgt_x;
  logic [SW:0]            w_acc_x;
  logic [SW:0]            w_lo;
  logic [SW:0]            w_hi;
  logic                   w_gt;
  logic                   w_lt;
  logic                   w_below;
  logic                   w_above;
  logic                   w_over;
  logic [4:0]             w_mask;
  logic [4:0]             w_nxtmask;
  logic [4:0]             w_kept;
  logic [5:0]             w_final;
  logic signed [6:0]      w_v;
  logic signed [6:0]      w_vt;
  logic [4:0]             w_vabs;
  logic [5:0]             w_tcode;
  logic                   w_start_ok;

  // Comparison of the accumulated sum against target and deadband limits
  always_comb begin
    w_tgt_sum = {r_tgt, {AVG_LOG2{1'b0}}};
    w_tgt_x   = {1'b0, w_tgt_sum};
    w_acc_x   = {1'b0, r_acc};
    w_lo      = (w_tgt_x >= DBS) ? (w_tgt_x - DBS) : '0;
    w_hi      = ((MAXS - w_tgt_x) >= DBS) ? (w_tgt_x + DBS) : MAXS;
    w_gt      = r_acc > w_tgt_sum;
    w_lt      = r_acc < w_tgt_sum;
    w_below   = w_acc_x < w_lo;
    w_above   = w_acc_x > w_hi;
  end

  // SAR bit resolution and final-code normalisation
  always_comb begin
    w_over    = r_sign ? w_lt : w_gt;
    w_mask    = 5'b00001 << r_bit;
    w_nxtmask = 5'b00001 << (r_bit - 3'd1);
    w_kept    = w_over ? (r_dac[4:0] & ~w_mask) : r_dac[4:0];
    w_final   = (w_kept == 5'd0) ? 6'd0 : {r_sign, w_kept};
  end

  // Tracking step on the signed code with saturation at +/-31
  always_comb begin
    w_v = {2'b00, r_dac[4:0]};
    if (r_dac[5]) begin
      w_v = -w_v;
    end
    w_vt = w_v;
    if (w_below && (w_v != 7'sd31)) begin
      w_vt = w_v + 7'sd1;
    end else if (w_above && (w_v != -7'sd31)) begin
      w_vt = w_v - 7'sd1;
    end
    w_vabs  = w_vt[6] ? 5'(-w_vt) : 5'(w_vt);
    w_tcode = (w_vt == 7'sd0) ? 6'd0 : {w_vt[6], w_vabs};
  end

  // Next-state and datapath update
  always_comb begin
    w_state_d  = r_state;
    w_tgt_d    = r_tgt;
    w_dac_d    = r_dac;
    w_upd_d    = 1'b0;
    w_busy_d   = r_busy;
    w_done_d   = r_done;
    w_cnt_d    = r_cnt;
    w_nsmp_d   = r_nsmp;
    w_acc_d    = r_acc;
    w_signph_d = r_signph;
    w_sign_d   = r_sign;
    w_bit_d    = r_bit;
    w_trk_d    = r_trk;
    w_start_ok = start && !r_busy;

    if (w_start_ok) begin
      w_tgt_d    = target;
      w_dac_d    = 6'd0;
      w_upd_d    = 1'b1;
      w_busy_d   = 1'b1;
      w_done_d   = 1'b0;
      w_signph_d = 1'b1;
      w_sign_d   = 1'b0;
      w_bit_d    = 3'd4;
      w_trk_d    = 1'b0;
      w_cnt_d    = '0;
      w_state_d  = S_SETTLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_d = S_IDLE;
        end
        S_DONE: begin
          if (track_en) begin
            w_state_d = S_TRACK;
          end
        end
        S_TRACK: begin
          if (!track_en) begin
            w_state_d = S_DONE;
          end else begin
            w_trk_d   = 1'b1;
            w_cnt_d   = '0;
            w_state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
            w_acc_d   = '0;
            w_nsmp_d  = '0;
            w_state_d = S_ACCUM;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          if (adc_valid) begin
            w_acc_d  = r_acc + SW'(adc_data);
            w_nsmp_d = r_nsmp + 1'b1;
            if (r_nsmp == NW'(NS - 1)) begin
              w_state_d = S_DECIDE;
            end
          end
        end
        S_DECIDE: begin
          w_cnt_d   = '0;
          w_state_d = S_SETTLE;
          if (r_trk) begin
            if (!track_en) begin
              w_state_d = S_DONE;
            end else if (w_tcode != r_dac) begin
              w_dac_d = w_tcode;
              w_upd_d = 1'b1;
            end
          end else if (r_signph) begin
            w_signph_d = 1'b0;
            w_sign_d   = w_gt;
            w_bit_d    = 3'd4;
            w_dac_d    = {w_gt, 5'b10000};
            w_upd_d    = 1'b1;
          end else if (r_bit == 3'd0) begin
            w_dac_d   = w_final;
            w_upd_d   = (w_final != r_dac);
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
            w_state_d = track_en ? S_TRACK : S_DONE;
          end else begin
            w_bit_d = r_bit - 3'd1;
            w_dac_d = {r_sign, w_kept | w_nxtmask};
            w_upd_d = 1'b1;
          end
        end
        default: begin
          w_state_d = S_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tgt    <= '0;
      r_dac    <= '0;
      r_upd    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_nsmp   <= '0;
      r_acc    <= '0;
      r_signph <= 1'b0;
      r_sign   <= 1'b0;
      r_bit    <= '0;
      r_trk    <= 1'b0;
    end else begin
      r_tgt    <= w_tgt_d;
      r_dac    <= w_dac_d;
      r_upd    <= w_upd_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
      r_cnt    <= w_cnt_d;
      r_nsmp   <= w_nsmp_d;
      r_acc    <= w_acc_d;
      r_signph <= w_signph_d;
      r_sign   <= w_sign_d;
      r_bit    <= w_bit_d;
      r_trk    <= w_trk_d;
    end
  end

  assign current_dac = r_dac;
  assign dac_update  = r_upd;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
